// File: rtl/crossing_scheduler.sv
// Two-direction intersection sequencer with all-red clearance, latched walk requests and night flashing.
// Optional emergency preemption is built only when XSCHED_PREEMPT_EN is defined.
module crossing_scheduler #(
    parameter int          C_INT_GREEN  = 10,
    parameter int          C_INT_YELLOW = 2,
    parameter int          C_INT_ALLRED = 1,
    parameter int          C_INT_WALK   = 5,
    parameter logic [11:0] C_COLORS     = 12'b100_010_110_111
) (
    input  logic       sysClk,
    input  logic       sysRst,
    input  logic       tick,
    input  logic       mode,
    input  logic [1:0] pedReq,
    input  logic       emgReq,
    output logic [1:0] stateA,
    output logic [1:0] stateB,
    output logic [2:0] rgbA,
    output logic [2:0] rgbB,
    output logic [1:0] pedPend,
    output logic       emgAck
);

    localparam int C_MAX_GY  = (C_INT_GREEN > C_INT_YELLOW) ? C_INT_GREEN : C_INT_YELLOW;
    localparam int C_MAX_AW  = (C_INT_ALLRED > C_INT_WALK) ? C_INT_ALLRED : C_INT_WALK;
    localparam int C_MAX_INT = (C_MAX_GY > C_MAX_AW) ? C_MAX_GY : C_MAX_AW;
    localparam int C_CNT_W   = $clog2(C_MAX_INT + 1);

    localparam logic [1:0] CODE_RED    = 2'd0;
    localparam logic [1:0] CODE_GREEN  = 2'd1;
    localparam logic [1:0] CODE_YELLOW = 2'd2;
    localparam logic [1:0] CODE_WALK   = 2'd3;

    localparam logic [2:0] RGB_RED    = C_COLORS[11:9];
    localparam logic [2:0] RGB_GREEN  = C_COLORS[8:6];
    localparam logic [2:0] RGB_YELLOW = C_COLORS[5:3];
    localparam logic [2:0] RGB_WALK   = C_COLORS[2:0];

    typedef enum logic [2:0] {
        S_ALLRED_B2A, S_A_GO, S_A_YEL, S_ALLRED_A2B, S_B_GO, S_B_YEL, S_WALK, S_NIGHT
    } state_t;

    state_t               state_q, state_d;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]           pend_q, pend_d;
    logic                 blink_q, blink_d;
    logic                 dir_b_q, dir_b_d;      // 1: the next green phase belongs to B
    logic                 ack_q, ack_d;
    logic [1:0]           code_a_q, code_a_d, code_b_q, code_b_d;
    logic [2:0]           rgb_a_q, rgb_a_d, rgb_b_q, rgb_b_d;
    logic                 hold;
    logic                 pend_clr;
    logic                 dwell_done;

    function automatic logic [C_CNT_W-1:0] last_count(input state_t s);
        case (s)
            S_A_GO, S_B_GO:   return C_CNT_W'(C_INT_GREEN - 1);
            S_A_YEL, S_B_YEL: return C_CNT_W'(C_INT_YELLOW - 1);
            S_WALK:           return C_CNT_W'(C_INT_WALK - 1);
            default:          return C_CNT_W'(C_INT_ALLRED - 1);
        endcase
    endfunction

    function automatic logic is_allred(input state_t s);
        return (s == S_ALLRED_B2A) || (s == S_ALLRED_A2B);
    endfunction

`ifdef XSCHED_PREEMPT_EN
    assign hold = emgReq && is_allred(state_q);
`else
    logic emg_unused;
    assign hold       = 1'b0;
    assign emg_unused = emgReq;
`endif

    assign dwell_done = tick && (cnt_q == last_count(state_q));

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d  = state_q;
        cnt_d    = cnt_q;
        blink_d  = blink_q;
        dir_b_d  = dir_b_q;
        ack_d    = 1'b0;
        pend_clr = 1'b0;

        case (state_q)
            S_ALLRED_B2A, S_ALLRED_A2B: begin
                if (dwell_done && !hold) begin
                    dir_b_d = (state_q == S_ALLRED_A2B);
                    if (mode) begin
                        state_d = S_NIGHT;
                    end else if (pend_q != 2'b00) begin
                        state_d  = S_WALK;
                        pend_clr = 1'b1;
                    end else begin
                        state_d = (state_q == S_ALLRED_A2B) ? S_B_GO : S_A_GO;
                    end
                end
            end
            S_A_GO:  if (dwell_done) state_d = S_A_YEL;
            S_A_YEL: if (dwell_done) state_d = S_ALLRED_A2B;
            S_B_GO:  if (dwell_done) state_d = S_B_YEL;
            S_B_YEL: if (dwell_done) state_d = S_ALLRED_B2A;
            S_WALK:  if (dwell_done) state_d = dir_b_q ? S_B_GO : S_A_GO;
            S_NIGHT: begin
                if (tick) begin
                    if (!mode) state_d = S_ALLRED_B2A;
                    else       blink_d = ~blink_q;
                end
            end
            default: state_d = S_ALLRED_B2A;
        endcase

`ifdef XSCHED_PREEMPT_EN
        if (emgReq) begin
            case (state_q)
                S_A_GO:          state_d = S_A_YEL;
                S_B_GO:          state_d = S_B_YEL;
                S_WALK, S_NIGHT: state_d = dir_b_q ? S_ALLRED_A2B : S_ALLRED_B2A;
                default:         ;
            endcase
        end
        ack_d = emgReq && is_allred(state_d);
`endif

        // Dwell restarts on every entry and stays at zero while preempt holds all-red.
        if ((state_d != state_q) || hold) begin
            cnt_d = '0;
        end else if (tick && (state_q != S_NIGHT)) begin
            cnt_d = cnt_q + 1'b1;
        end

        if ((state_d == S_NIGHT) && (state_q != S_NIGHT)) blink_d = 1'b1;

        // A request seen on the walk-entry cycle survives the clear.
        pend_d = (pend_q & ~{2{pend_clr}}) | pedReq;

        code_a_d = CODE_RED;
        code_b_d = CODE_RED;
        rgb_a_d  = RGB_RED;
        rgb_b_d  = RGB_RED;
        case (state_d)
            S_A_GO:  begin code_a_d = CODE_GREEN;  rgb_a_d = RGB_GREEN;  end
            S_A_YEL: begin code_a_d = CODE_YELLOW; rgb_a_d = RGB_YELLOW; end
            S_B_GO:  begin code_b_d = CODE_GREEN;  rgb_b_d = RGB_GREEN;  end
            S_B_YEL: begin code_b_d = CODE_YELLOW; rgb_b_d = RGB_YELLOW; end
            S_WALK: begin
                code_a_d = CODE_WALK; code_b_d = CODE_WALK;
                rgb_a_d  = RGB_WALK;  rgb_b_d  = RGB_WALK;
            end
            S_NIGHT: begin
                code_a_d = CODE_YELLOW;
                code_b_d = CODE_YELLOW;
                rgb_a_d  = blink_d ? RGB_YELLOW : 3'b000;
                rgb_b_d  = blink_d ? RGB_YELLOW : 3'b000;
            end
            default: ;
        endcase
    end

    always_ff @(posedge sysClk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (sysRst) begin
            state_q  <= S_ALLRED_B2A;
            cnt_q    <= '0;
            pend_q   <= 2'b00;
            blink_q  <= 1'b1;
            dir_b_q  <= 1'b0;
            ack_q    <= 1'b0;
            code_a_q <= CODE_RED;
            code_b_q <= CODE_RED;
            rgb_a_q  <= RGB_RED;
            rgb_b_q  <= RGB_RED;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            blink_q  <= blink_d;
            dir_b_q  <= dir_b_d;
            ack_q    <= ack_d;
            code_a_q <= code_a_d;
            code_b_q <= code_b_d;
            rgb_a_q  <= rgb_a_d;
            rgb_b_q  <= rgb_b_d;
        end
    end

    assign stateA  = code_a_q;
    assign stateB  = code_b_q;
    assign rgbA    = rgb_a_q;
    assign rgbB    = rgb_b_q;
    assign pedPend = pend_q;
    assign emgAck  = ack_q;

endmodule

// File: tb/tb_crossing_scheduler.sv
// Bench for crossing_scheduler: expected light phases are queued as a table and replayed tick by tick.
// The preempt expectations switch on XSCHED_PREEMPT_EN to match the build under test.
module tb_crossing_scheduler;

    localparam logic [1:0] RED = 2'd0, GRN = 2'd1, YEL = 2'd2, WLK = 2'd3;
    localparam logic [2:0] C_R = 3'b100, C_G = 3'b010, C_Y = 3'b110, C_W = 3'b111, C_OFF = 3'b000;

    logic       sysClk = 1'b0;
    logic       sysRst, tick, mode, emgReq;
    logic [1:0] pedReq;
    logic [1:0] stateA, stateB, pedPend;
    logic [2:0] rgbA, rgbB;
    logic       emgAck;

    int total = 0;
    int bad   = 0;

    crossing_scheduler dut (
        .sysClk (sysClk),
        .sysRst (sysRst),
        .tick   (tick),
        .mode   (mode),
        .pedReq (pedReq),
        .emgReq (emgReq),
        .stateA (stateA),
        .stateB (stateB),
        .rgbA   (rgbA),
        .rgbB   (rgbB),
        .pedPend(pedPend),
        .emgAck (emgAck)
    );

    always #5 sysClk = ~sysClk;

    typedef struct {
        logic [1:0] sa, sb;   // expected light codes
        logic [2:0] ra, rb;   // expected colours
        logic [1:0] pp;       // expected pending walk requests
        int         n;        // ticks spent in this phase
        int         md;       // mode applied at phase start, -1 keeps it
        int         em;       // emgReq applied at phase start, -1 keeps it
        logic [1:0] rp;       // pedReq pulsed for 3 clocks at phase start
        logic [1:0] rq;       // pedReq held during the phase's final tick
    } phase_t;

    phase_t exp_q[$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic phase_t ph(input logic [1:0] sa, input logic [1:0] sb, input logic [2:0] ra,
                                  input logic [2:0] rb, input logic [1:0] pp, input int n);
        phase_t p;
        p.sa = sa; p.sb = sb; p.ra = ra; p.rb = rb; p.pp = pp; p.n = n;
        p.md = -1; p.em = -1; p.rp = 2'b00; p.rq = 2'b00;
        return p;
    endfunction

    function automatic phase_t allred(input logic [1:0] pp); return ph(RED, RED, C_R, C_R, pp, 1);  endfunction
    function automatic phase_t a_go(input logic [1:0] pp);   return ph(GRN, RED, C_G, C_R, pp, 10); endfunction
    function automatic phase_t a_yel(input logic [1:0] pp);  return ph(YEL, RED, C_Y, C_R, pp, 2);  endfunction
    function automatic phase_t b_go(input logic [1:0] pp);   return ph(RED, GRN, C_R, C_G, pp, 10); endfunction
    function automatic phase_t b_yel(input logic [1:0] pp);  return ph(RED, YEL, C_R, C_Y, pp, 2);  endfunction
    function automatic phase_t walk(input logic [1:0] pp);   return ph(WLK, WLK, C_W, C_W, pp, 5);  endfunction

    task automatic push(input phase_t p);
        exp_q.push_back(p);
    endtask

    // One tick pulse followed by 9 idle clocks; all driving happens on the falling edge.
    task automatic pulse_tick(input logic [1:0] rq);
        pedReq = rq;
        tick   = 1'b1;
        @(negedge sysClk);
        tick   = 1'b0;
        pedReq = 2'b00;
        repeat (9) @(negedge sysClk);
    endtask

    task automatic run_phase(input string tag, input phase_t p);
        if (p.md >= 0) mode = p.md[0];
        if (p.em >= 0) emgReq = p.em[0];
        if (p.rp != 2'b00) begin
            pedReq = p.rp;
            repeat (3) @(negedge sysClk);
            pedReq = 2'b00;
        end
        for (int k = 0; k < p.n; k++) begin
            check({tag, " codes"}, 16'({stateA, stateB}), 16'({p.sa, p.sb}));
            check({tag, " rgb"}, 16'({rgbA, rgbB}), 16'({p.ra, p.rb}));
            check({tag, " pend/ack"}, 16'({pedPend, emgAck}), 16'({p.pp, 1'b0}));
            pulse_tick((k == p.n - 1) ? p.rq : 2'b00);
        end
    endtask

    task automatic run_queue(input string tag);
        phase_t p;
        while (exp_q.size() > 0) begin
            p = exp_q.pop_front();
            run_phase(tag, p);
        end
    endtask

    initial begin
        phase_t p;
        sysRst = 1'b1; tick = 1'b0; mode = 1'b0; emgReq = 1'b0; pedReq = 2'b00;
        repeat (3) @(negedge sysClk);
        check("reset codes", 16'({stateA, stateB}), 16'({RED, RED}));
        check("reset rgb", 16'({rgbA, rgbB}), 16'({C_R, C_R}));
        check("reset pend/ack", 16'({pedPend, emgAck}), 16'h0);
        sysRst = 1'b0;

        // Plain cycle
        push(allred(2'b00)); push(a_go(2'b00)); push(a_yel(2'b00));
        push(allred(2'b00)); push(b_go(2'b00)); push(b_yel(2'b00));
        run_queue("cycle");

        // Walk request during A_GO, second request landing on the walk-entry cycle
        push(allred(2'b00));
        p = a_go(2'b01); p.rp = 2'b01; push(p);
        push(a_yel(2'b01));
        p = allred(2'b01); p.rq = 2'b10; push(p);
        push(walk(2'b10)); push(b_go(2'b10)); push(b_yel(2'b10));
        push(allred(2'b10)); push(walk(2'b00)); push(a_go(2'b00));
        push(a_yel(2'b00)); push(allred(2'b00)); push(b_go(2'b00)); push(b_yel(2'b00));
        run_queue("walk");

        // Night mode requested mid A_GO, left again after three blink steps
        push(allred(2'b00));
        p = a_go(2'b00); p.md = 1; push(p);
        push(a_yel(2'b00)); push(allred(2'b00));
        push(ph(YEL, YEL, C_Y, C_Y, 2'b00, 1));
        push(ph(YEL, YEL, C_OFF, C_OFF, 2'b00, 1));
        push(ph(YEL, YEL, C_Y, C_Y, 2'b00, 1));
        p = ph(YEL, YEL, C_OFF, C_OFF, 2'b00, 1); p.md = 0; push(p);
        push(allred(2'b00)); push(a_go(2'b00)); push(a_yel(2'b00));
        push(allred(2'b00)); push(b_go(2'b00));
        run_queue("night");

        // Reset in the middle of B_YEL with requests pending
        pedReq = 2'b11;
        repeat (3) @(negedge sysClk);
        pedReq = 2'b00;
        check("pre-reset codes", 16'({stateA, stateB}), 16'({RED, YEL}));
        check("pre-reset pend", 16'(pedPend), 16'(2'b11));
        pulse_tick(2'b00);
        sysRst = 1'b1;
        @(negedge sysClk);
        sysRst = 1'b0;
        check("mid reset codes", 16'({stateA, stateB}), 16'({RED, RED}));
        check("mid reset rgb", 16'({rgbA, rgbB}), 16'({C_R, C_R}));
        check("mid reset pend/ack", 16'({pedPend, emgAck}), 16'h0);
        push(allred(2'b00)); push(a_go(2'b00)); push(a_yel(2'b00));
        push(allred(2'b00)); push(b_go(2'b00)); push(b_yel(2'b00));
        run_queue("post-reset");

        // Emergency request at tick 4 of A_GO
        push(allred(2'b00));
        p = a_go(2'b00); p.n = 4; push(p);
        run_queue("emg-pre");
`ifdef XSCHED_PREEMPT_EN
        emgReq = 1'b1;
        repeat (2) @(negedge sysClk);
        push(a_yel(2'b00));
        run_queue("emg-yel");
        for (int k = 0; k < 3; k++) begin
            check("emg hold codes", 16'({stateA, stateB}), 16'({RED, RED}));
            check("emg hold ack", 16'(emgAck), 16'h1);
            pulse_tick(2'b00);
        end
        emgReq = 1'b0;
        repeat (2) @(negedge sysClk);
        push(allred(2'b00)); push(b_go(2'b00)); push(b_yel(2'b00));
        run_queue("emg-release");
`else
        p = a_go(2'b00); p.n = 6; p.em = 1; push(p);
        push(a_yel(2'b00)); push(allred(2'b00));
        p = b_go(2'b00); p.em = 0; push(p);
        push(b_yel(2'b00));
        run_queue("emg-ignored");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
